// File: rtl/as6d_vp_buffer_rd_unpack.sv
// Splits 128-bit FWFT FIFO words into 32-bit valid/ready beats, lowest lane first, grouped into frames.
// Optional stall counter enabled by defining AS6D_VP_UNPACK_STALL_CNT_EN.
module as6d_vp_buffer_rd_unpack #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] frame_len_cfg,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  input  logic                 fifo_rd_data_val,
  output logic                 fifo_rd_en,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [LEN_WIDTH-1:0] frame_cnt
`ifdef AS6D_VP_UNPACK_STALL_CNT_EN
  ,
  input  logic                 stall_cnt_clr,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  state_t               r_state;
  logic [IN_WIDTH-1:0]  r_hold;
  logic [LANE_W-1:0]    r_lane;
  logic [LEN_WIDTH-1:0] r_beat_cnt;
  logic [LEN_WIDTH-1:0] r_len_q;
  logic                 r_cfg_err;
  logic [LEN_WIDTH-1:0] r_frame_cnt;

  logic w_send;
  logic w_accept;
  logic w_last;
  logic w_lane_end;
  logic w_word_done;
  logic w_restart;
  logic w_pop;

  assign w_send      = (r_state == S_SEND);
  assign w_accept    = w_send & out_ready;
  assign w_last      = (r_beat_cnt == (r_len_q - LEN_WIDTH'(1)));
  assign w_lane_end  = (r_lane == LANE_W'(RATIO - 1));
  assign w_word_done = w_accept & (w_last | w_lane_end);
  assign w_restart   = enable & (frame_len_cfg != '0);

  // A frame end without a restart goes idle, so it must not pull the next word.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_FETCH: w_pop = fifo_rd_data_val;
      S_SEND:  w_pop = w_word_done & fifo_rd_data_val & (~w_last | w_restart);
      default: w_pop = 1'b0;
    endcase
  end

  assign fifo_rd_en = w_pop;
  assign out_valid  = w_send;
  assign out_last   = w_send & w_last;
  assign out_data   = r_hold[int'(r_lane)*OUT_WIDTH +: OUT_WIDTH];
  assign busy       = (r_state != S_IDLE);
  assign cfg_err    = r_cfg_err;
  assign frame_cnt  = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_lane      <= '0;
      r_beat_cnt  <= '0;
      r_len_q     <= '0;
      r_cfg_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            if (frame_len_cfg != '0) begin
              r_len_q    <= frame_len_cfg;
              r_beat_cnt <= '0;
              r_state    <= S_FETCH;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (w_pop) begin
            r_hold  <= fifo_rd_data;
            r_lane  <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
            r_lane     <= r_lane + LANE_W'(1);
            if (w_last) begin
              r_frame_cnt <= r_frame_cnt + LEN_WIDTH'(1);
              if (w_restart) begin
                r_len_q    <= frame_len_cfg;
                r_beat_cnt <= '0;
              end
            end
            // Remaining lanes of a word are dropped once its frame is complete.
            if (w_last && !w_restart) begin
              r_state <= S_IDLE;
              if (frame_len_cfg == '0) r_cfg_err <= 1'b1;
            end else if (w_word_done) begin
              if (w_pop) begin
                r_hold <= fifo_rd_data;
                r_lane <= '0;
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AS6D_VP_UNPACK_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall   = (w_send & ~out_ready) | ((r_state == S_FETCH) & ~fifo_rd_data_val);
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_as6d_vp_buffer_rd_unpack.sv
// Directed bench for as6d_vp_buffer_rd_unpack: FIFO model, frame-level beat model and per-cycle stream monitor.
module tb_as6d_vp_buffer_rd_unpack;
  localparam int IW = 128;
  localparam int OW = 32;
  localparam int LW = 16;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] frame_len_cfg = '0;
  logic [IW-1:0] fifo_rd_data;
  logic          fifo_rd_data_val;
  logic          fifo_rd_en;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          cfg_err;
  logic [LW-1:0] frame_cnt;

  always #5 clk = ~clk;

  as6d_vp_buffer_rd_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .frame_len_cfg    (frame_len_cfg),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_rd_data_val (fifo_rd_data_val),
    .fifo_rd_en       (fifo_rd_en),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .cfg_err          (cfg_err),
    .frame_cnt        (frame_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word k, lane j carries 32'hC0DE0000 + 16*k + j.
  function automatic logic [IW-1:0] mkw(input int k);
    logic [IW-1:0] w;
    for (int j = 0; j < R; j++) w[j*OW +: OW] = 32'hC0DE_0000 + 32'(16*k + j);
    return w;
  endfunction

  // FWFT FIFO model: bench writes wr_ptr, pop process writes rd_ptr.
  logic [IW-1:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  logic pop_s = 1'b0;
  assign fifo_rd_data_val = (wr_ptr != rd_ptr);
  assign fifo_rd_data     = fmem[rd_ptr % 64];

  task automatic push(input int k);
    fmem[wr_ptr % 64] = mkw(k);
    wr_ptr = wr_ptr + 1;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (pop_s) begin
      rd_ptr = rd_ptr + 1;
      pops = pops + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Frame model: each frame takes ceil(L/R) fresh words, emits first L lanes, last on beat L.
  logic [IW-1:0] mw [$];
  logic [OW-1:0] exp_d [$];
  logic          exp_l [$];

  task automatic model_frame(input int L);
    logic [IW-1:0] w;
    for (int b = 0; b < L; b++) begin
      w = mw[b / R];
      exp_d.push_back(w[(b % R)*OW +: OW]);
      exp_l.push_back(b == L - 1);
    end
    for (int n = 0; n < (L + R - 1) / R; n++) void'(mw.pop_front());
  endtask

  // Stream monitor.
  int acc_cnt = 0;
  int acc_cyc [0:255];
  logic [OW-1:0] acc_dat [0:255];
  logic acc_lst [0:255];
  logic prev_stall = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  always @(negedge clk) begin
    pop_s = fifo_rd_en;
    if (rst_n) begin
      if (fifo_rd_en) chk("rd_en_gated", {fifo_rd_data_val, busy}, 2'b11);
      if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_beat", out_data, 0);
          if (out_data == 0) chk("unexpected_beat_v", out_valid, 0);
        end else begin
          chk("beat_data", out_data, exp_d.pop_front());
          chk("beat_last", out_last, exp_l.pop_front());
        end
        acc_cyc[acc_cnt % 256] = cyc;
        acc_dat[acc_cnt % 256] = out_data;
        acc_lst[acc_cnt % 256] = out_last;
        acc_cnt++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_acc(input int target, input string nm);
    int n = 0;
    while (acc_cnt < target && n < 300) begin
      tick();
      n++;
    end
    chk(nm, acc_cnt >= target, 1'b1);
  endtask

  task automatic start_test();
    rst_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    frame_len_cfg = '0;
    wr_ptr = rd_ptr;
    exp_d.delete();
    exp_l.delete();
    mw.delete();
    tick();
    chk("rst_outs", {out_valid, out_last, busy, cfg_err, fifo_rd_en}, 5'b0);
    chk("rst_data", {out_data, frame_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ab, pb;
    // 1: basic frame of 8 over two words
    start_test();
    ab = acc_cnt; pb = pops;
    frame_len_cfg = 16'd8;
    push(0); push(1);
    mw.push_back(mkw(0)); mw.push_back(mkw(1));
    model_frame(8);
    out_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk); chk("t1_idle_busy", busy, 1'b0);
    @(negedge clk); chk("t1_fetch", {busy, fifo_rd_en, out_valid}, 3'b110);
    @(negedge clk); chk("t1_first_beat", {out_valid, out_data}, {1'b1, 32'hC0DE_0000});
    wait_acc(ab + 8, "t1_done");
    tick();
    chk("t1_frame_cnt", frame_cnt, 16'd1);
    chk("t1_pops", pops - pb, 2);
    chk("t1_no_gaps", acc_cyc[(ab + 7) % 256] - acc_cyc[ab % 256], 7);
    chk("t1_last_word", acc_dat[(ab + 7) % 256], 32'hC0DE_0013);
    chk("t1_drained", exp_d.size(), 0);

    // 2: partial word, frame length 6
    start_test();
    ab = acc_cnt; pb = pops;
    frame_len_cfg = 16'd6;
    for (int k = 0; k < 4; k++) mw.push_back(mkw(k));
    model_frame(6); model_frame(6);
    push(0); push(1); push(2);
    out_ready = 1'b1;
    enable = 1'b1;
    wait_acc(ab + 7, "t2_f2_start");
    chk("t2_pops_at_f2", pops - pb, 3);
    chk("t2_frame_cnt1", frame_cnt, 16'd1);
    chk("t2_f1_last", {acc_lst[(ab + 5) % 256], acc_dat[(ab + 5) % 256]}, {1'b1, 32'hC0DE_0011});
    chk("t2_f2_first", acc_dat[(ab + 6) % 256], 32'hC0DE_0020);
    push(3);
    wait_acc(ab + 12, "t2_done");
    tick();
    chk("t2_frame_cnt2", frame_cnt, 16'd2);
    chk("t2_pops", pops - pb, 4);
    chk("t2_drained", exp_d.size(), 0);

    // 3: backpressure pattern 1,0,0,1
    start_test();
    ab = acc_cnt; pb = pops;
    frame_len_cfg = 16'd8;
    push(0); push(1);
    mw.push_back(mkw(0)); mw.push_back(mkw(1));
    model_frame(8);
    enable = 1'b1;
    for (int i = 0; i < 200 && acc_cnt < ab + 8; i++) begin
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    chk("t3_done", acc_cnt >= ab + 8, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("t3_pops", pops - pb, 2);
    chk("t3_frame_cnt", frame_cnt, 16'd1);
    chk("t3_drained", exp_d.size(), 0);

    // 4: FIFO underrun between words
    start_test();
    ab = acc_cnt; pb = pops;
    frame_len_cfg = 16'd8;
    push(0);
    mw.push_back(mkw(0)); mw.push_back(mkw(1));
    model_frame(8);
    out_ready = 1'b1;
    enable = 1'b1;
    wait_acc(ab + 4, "t4_word0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_underrun", {busy, out_valid, fifo_rd_en}, 3'b100);
    end
    tick();
    push(1);
    @(negedge clk); chk("t4_pop_word1", {fifo_rd_en, out_valid}, 2'b10);
    @(negedge clk); chk("t4_resume", {out_valid, out_data}, {1'b1, 32'hC0DE_0010});
    wait_acc(ab + 8, "t4_done");
    tick();
    chk("t4_frame_cnt", frame_cnt, 16'd1);
    chk("t4_pops", pops - pb, 2);

    // 5a: zero length is flagged and sticky
    start_test();
    ab = acc_cnt; pb = pops;
    push(0);
    enable = 1'b1;
    repeat (3) tick();
    chk("t5a_cfg_err", {cfg_err, busy, out_valid}, 3'b100);
    chk("t5a_no_pops", pops - pb, 0);
    mw.push_back(mkw(0));
    model_frame(4);
    out_ready = 1'b1;
    frame_len_cfg = 16'd4;
    wait_acc(ab + 4, "t5a_done");
    tick();
    chk("t5a_sticky", {cfg_err, frame_cnt}, {1'b1, 16'd1});

    // 5b: enable dropped mid-frame
    start_test();
    ab = acc_cnt; pb = pops;
    frame_len_cfg = 16'd4;
    push(0); push(1);
    mw.push_back(mkw(0));
    model_frame(4);
    out_ready = 1'b1;
    enable = 1'b1;
    wait_acc(ab + 1, "t5b_first");
    enable = 1'b0;
    wait_acc(ab + 4, "t5b_done");
    repeat (3) tick();
    chk("t5b_idle", {busy, out_valid}, 2'b00);
    chk("t5b_pops", pops - pb, 1);
    chk("t5b_frame_cnt", frame_cnt, 16'd1);
    chk("t5b_drained", exp_d.size(), 0);

    // 5c: length change mid-frame applies to the next frame
    start_test();
    ab = acc_cnt; pb = pops;
    frame_len_cfg = 16'd4;
    push(0); push(1); push(2);
    for (int k = 0; k < 3; k++) mw.push_back(mkw(k));
    model_frame(4); model_frame(8);
    out_ready = 1'b1;
    enable = 1'b1;
    wait_acc(ab + 1, "t5c_first");
    frame_len_cfg = 16'd8;
    wait_acc(ab + 12, "t5c_done");
    tick();
    chk("t5c_f1_last", {acc_lst[(ab + 3) % 256], acc_dat[(ab + 3) % 256]}, {1'b1, 32'hC0DE_0003});
    chk("t5c_f2_last", {acc_lst[(ab + 11) % 256], acc_dat[(ab + 11) % 256]}, {1'b1, 32'hC0DE_0023});
    chk("t5c_frame_cnt", frame_cnt, 16'd2);
    chk("t5c_pops", pops - pb, 3);

    // 6: async reset mid-frame
    start_test();
    ab = acc_cnt;
    frame_len_cfg = 16'd8;
    push(0); push(1); push(2);
    mw.push_back(mkw(0)); mw.push_back(mkw(1));
    model_frame(8);
    out_ready = 1'b1;
    enable = 1'b1;
    wait_acc(ab + 3, "t6_three");
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {out_valid, out_last, busy, cfg_err, fifo_rd_en}, 5'b0);
    chk("t6_rst_data", {out_data, frame_cnt}, 0);
    exp_d.delete();
    exp_l.delete();
    mw.delete();
    mw.push_back(mkw(1)); mw.push_back(mkw(2));
    model_frame(8);
    repeat (2) tick();
    rst_n = 1'b1;
    ab = acc_cnt; pb = pops;
    tick();
    chk("t6_frame_cnt0", frame_cnt, 16'd0);
    wait_acc(ab + 8, "t6_done");
    tick();
    chk("t6_first", acc_dat[ab % 256], 32'hC0DE_0010);
    chk("t6_frame_cnt1", frame_cnt, 16'd1);
    chk("t6_pops", pops - pb, 2);
    chk("t6_drained", exp_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/as6d_vp_buffer_rd_unpack.md
Name: as6d_vp_buffer_rd_unpack

Overview:
Downstream consumer of the 4096x128 FWFT async FIFO wrapper, running in the FIFO read clock domain. Pops 128-bit words through the FWFT interface (data and valid visible before pop) and emits them as 32-bit beats on a valid/ready stream, lowest lane first. Beats are grouped into frames of programmable length with a last marker. Every frame starts on a word boundary.

Parameters:
IN_WIDTH, 128, FIFO word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 32, output beat width.
LEN_WIDTH, 16, width of the frame length config and the frame counter.
RATIO (localparam), IN_WIDTH/OUT_WIDTH, beats per FIFO word (4 at defaults).

Ports:
clk  input  1  read-domain clock, same clock as the FIFO rd_clk.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  run enable; sampled only at frame boundaries.
frame_len_cfg  input  LEN_WIDTH  beats per frame; 0 is illegal.
fifo_rd_data  input  IN_WIDTH  FWFT head word.
fifo_rd_data_val  input  1  FWFT head valid (equals ~empty).
fifo_rd_en  output  1  pop strobe, combinational.
out_data  output  OUT_WIDTH  beat data.
out_valid  output  1  beat valid.
out_ready  input  1  sink ready.
out_last  output  1  final beat of the frame.
busy  output  1  state != IDLE.
cfg_err  output  1  sticky: an illegal frame_len_cfg was seen at frame start.
frame_cnt  output  LEN_WIDTH  number of completed frames; wraps.

Behaviour:
- Reset values: all outputs 0; hold register, lane_idx, beat_cnt and len_q are 0; state = IDLE.
- FSM states:
  - IDLE: moves to FETCH when enable=1 and frame_len_cfg!=0. On that edge it latches len_q = frame_len_cfg and clears beat_cnt.
  - IDLE with enable=1 and frame_len_cfg==0: sets cfg_err and stays in IDLE.
  - FETCH: holding register is empty. fifo_rd_en = fifo_rd_data_val. A pop loads hold_data, sets lane_idx=0 and moves to SEND.
  - SEND: out_valid=1; out_data = hold_data[lane_idx*OUT_WIDTH +: OUT_WIDTH]; out_last = (beat_cnt == len_q-1).
- Beat accepted (out_valid & out_ready): beat_cnt increments. lane_idx increments, or is released when it reaches RATIO-1.
- Word release with more beats remaining in the frame:
  - If fifo_rd_data_val=1: pop in the same cycle (fifo_rd_en=1), load the new word, stay in SEND. No bubble between words.
  - Otherwise go to FETCH.
- Last beat accepted: frame_cnt increments and the current word is released even if lane_idx < RATIO-1; the remaining lanes are discarded.
  - If enable=1 and frame_len_cfg!=0: re-latch len_q, clear beat_cnt, pop the next word if available (same-cycle pop, else FETCH).
  - Otherwise go to IDLE. If frame_len_cfg==0 at this point, set cfg_err.
- fifo_rd_en is asserted only when fifo_rd_data_val=1. It is never asserted in IDLE.
- Stream rules: out_data and out_valid hold stable while out_valid & ~out_ready. enable going low mid-frame has no effect until the frame ends.
- Latency: a word present at the FIFO head while in FETCH is popped in cycle N; its first beat is valid in cycle N+1. Sustained throughput is 1 beat/cycle.
- frame_len_cfg changes mid-frame are ignored (len_q is used).
- frame_cnt wraps from 2^LEN_WIDTH-1 to 0.
- cfg_err is cleared only by reset.
- Async reset mid-frame: everything returns to reset values. Words already popped are lost; the FIFO is not rewound.

Optional Feature:
Macro: AS6D_VP_UNPACK_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits, reset 0) and input stall_cnt_clr (1 bit).
  - stall_cnt increments on every cycle in SEND with out_ready=0, and on every cycle in FETCH with fifo_rd_data_val=0.
  - It saturates at 0xFFFFFFFF.
  - stall_cnt_clr=1 forces it to 0 next cycle, with priority over increment.
- Not defined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
1. Basic frame: frame_len_cfg=8, enable=1, push 2 words, out_ready=1 constantly -> 8 beats, no gaps; lanes in order [31:0],[63:32],[95:64],[127:96] of word0, then word1; out_last only on beat 8; frame_cnt=1; 2 pops.
2. Partial word: frame_len_cfg=6, push 3 words -> frame 1 ends after word1 lane1 and lanes 2-3 are dropped; frame 2 starts at word2 lane0; 3 pops total by the first beat of frame 2.
3. Backpressure: out_ready toggles 1,0,0,1 repeatedly -> out_data/out_valid stable through each stall; beat order unchanged; no extra pops.
4. FIFO underrun: FIFO empty between word0 and word1 for 5 cycles -> FETCH; out_valid=0 for those cycles; fifo_rd_en=0 while fifo_rd_data_val=0; resumes 1 cycle after word1 appears.
5. Config edge cases:
   - frame_len_cfg=0 with enable=1 -> cfg_err=1, busy=0, no pops.
   - enable dropped mid-frame -> the frame completes, then IDLE.
   - frame_len_cfg changed mid-frame -> takes effect next frame.
6. Reset mid-frame: assert rst_n=0 after beat 3 of 8 -> all outputs 0 immediately; after release with enable=1 a new frame starts at the next FIFO word; frame_cnt=0.
